fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the ARMv4 message-decoder core, sitting directly upstream of the control unit. Owns the program counter, fetches 32-bit words from instruction memory over a req/ack handshake, and presents the registered instruction plus its pre-split decode fields (Cond, Op, Funct, Rd, sh) to the control unit. Consumes the control unit's PCSrc together with the datapath result to select the next PC.

## Interface
- ADDR_W, 32, PC and memory address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  ADDR_W  word address, bits [1:0] always 0
- imem_ack  in  1  memory accepts request and drives imem_rdata this cycle
- imem_rdata  in  32  instruction word, valid only with imem_ack
- instr_valid  out  1  instr and fields hold a fetched instruction
- instr_ready  in  1  downstream consumes instruction this cycle
- pc_src  in  1  PCSrc from control unit, sampled only on consume
- result  in  ADDR_W  branch/PC-write target, sampled only on consume
- instr  out  32  registered instruction word
- pc_plus8  out  ADDR_W  PC of held instruction + 8 (R15 read value)
- cond  out  4  instr[31:28]
- op  out  2  instr[27:26]
- funct  out  6  instr[25:20]
- rd  out  4  instr[15:12]
- sh  out  2  instr[6:5]

## Operation
- States: IDLE, REQ, HOLD (plus FAULT when FETCH_ALIGN_FAULT_EN).
- IDLE: entered on reset; next cycle -> REQ. Never re-entered except by reset.
- REQ: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, -> HOLD. No ack: stay, address stable.
- HOLD: instr_valid=1; instr and fields stable. On instr_valid&&instr_ready (consume): pc <= pc_src ? {result[ADDR_W-1:2],2'b00} : pc+4; -> REQ.
- pc_src/result ignored in every cycle that is not a consume cycle.
- pc+4 wraps modulo 2^ADDR_W (32'hFFFF_FFFC -> 0).
- Fields are pure slices of the registered instr; no decode logic.
- Reset mid-request: imem_req drops asynchronously; any ack in the reset cycle is ignored.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=0, all fields 0, instr_valid=0, pc_plus8=RESET_PC+8.
- First rising edge after rst deasserts: IDLE->REQ; imem_req high the following cycle.
- Ack in cycle N -> instr_valid high in N+1.
- Consume in cycle M -> imem_req high in M+1 with new address; instr_valid low in M+1.
- Zero-wait memory: one instruction every 2 cycles; each memory wait state adds 1.
- instr_ready while instr_valid=0: no effect.
- Outputs registered; no combinational path from inputs to outputs.

## Configuration
- FETCH_ALIGN_FAULT_EN defined: adds output align_fault (1 bit, reset 0). Consume with pc_src=1 and result[1:0]!=0 -> align_fault=1 (sticky), state FAULT, no further requests until reset; pc not updated.
- Undefined: port absent, result[1:0] silently cleared, no FAULT state.

## Structure
- Shared package fetch_pkg: state enum (IDLE, REQ, HOLD, FAULT), RESET_PC default, field bit-position constants (COND_MSB/LSB, OP_*, FUNCT_*, RD_*, SH_*).
- One sub-module: instr_splitter (combinational field slicing from instr), reusable by later stages.

## Test plan
- Reset release, ack tied high, instr_ready high: imem_addr sequence 0x0, 0x4, 0x8; instr_valid high every second cycle.
- imem_rdata=32'hE3A0_1005 with ack: next cycle cond=4'hE, op=2'b00, funct=6'b111010, rd=4'h1, pc_plus8=pc+8.
- Consume with pc_src=1, result=0x0000_0040: next imem_addr=0x40; pc_src=1 outside consume has no effect.
- Ack delayed 3 cycles, instr_ready low 4 cycles in HOLD: imem_addr and instr stable, exactly one request per instruction.
- RESET_PC=32'hFFFF_FFFC, sequential consume: next imem_addr=0x0; rst asserted mid-REQ -> imem_req=0 immediately, restart at RESET_PC.
- With FETCH_ALIGN_FAULT_EN: consume pc_src=1, result=0x42 -> align_fault=1, imem_req stays 0; without it -> imem_addr=0x40.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage and later decode stages:
// the fetch state encoding, the default reset PC and the bit positions of the
// ARMv4 decode fields.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      HOLD  = 2'd2,
      FAULT = 2'd3
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam int unsigned COND_MSB  = 32'd31;
   localparam int unsigned COND_LSB  = 32'd28;
   localparam int unsigned OP_MSB    = 32'd27;
   localparam int unsigned OP_LSB    = 32'd26;
   localparam int unsigned FUNCT_MSB = 32'd25;
   localparam int unsigned FUNCT_LSB = 32'd20;
   localparam int unsigned RD_MSB    = 32'd15;
   localparam int unsigned RD_LSB    = 32'd12;
   localparam int unsigned SH_MSB    = 32'd6;
   localparam int unsigned SH_LSB    = 32'd5;

   // True when the two low address bits do not describe a word boundary.
   function automatic logic is_unaligned(input logic [1:0] lo_bits);
      return (lo_bits != 2'b00);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory req/ack on one side, the registered
// instruction plus decode fields towards the control unit on the other.
// Optional align_fault member exists only when FETCH_ALIGN_FAULT_EN is defined.
interface fetch_unit_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [31:0]       imem_rdata;
   logic              instr_valid;
   logic              instr_ready;
   logic              pc_src;
   logic [ADDR_W-1:0] result;
   logic [31:0]       instr;
   logic [ADDR_W-1:0] pc_plus8;
   logic [3:0]        cond;
   logic [1:0]        op;
   logic [5:0]        funct;
   logic [3:0]        rd;
   logic [1:0]        sh;
`ifdef FETCH_ALIGN_FAULT_EN
   logic              align_fault;
`endif

   // Fetch unit side.
   modport master (
`ifdef FETCH_ALIGN_FAULT_EN
      output align_fault,
`endif
      output imem_req, imem_addr, instr_valid, instr, pc_plus8,
             cond, op, funct, rd, sh,
      input  imem_ack, imem_rdata, instr_ready, pc_src, result
   );

   // Memory / control-unit side.
   modport slave (
`ifdef FETCH_ALIGN_FAULT_EN
      input  align_fault,
`endif
      input  imem_req, imem_addr, instr_valid, instr, pc_plus8,
             cond, op, funct, rd, sh,
      output imem_ack, imem_rdata, instr_ready, pc_src, result
   );

endinterface

// File: rtl/fetch_unit_instr_splitter.sv
// Pure slicing of an ARMv4 instruction word into its decode fields.
// No decode logic lives here so later stages can reuse it unchanged.
module instr_splitter
   import fetch_pkg::*;
(
   input  logic [31:0] i_instr,
   output logic [3:0]  o_cond,
   output logic [1:0]  o_op,
   output logic [5:0]  o_funct,
   output logic [3:0]  o_rd,
   output logic [1:0]  o_sh
);

   assign o_cond  = i_instr[COND_MSB:COND_LSB];
   assign o_op    = i_instr[OP_MSB:OP_LSB];
   assign o_funct = i_instr[FUNCT_MSB:FUNCT_LSB];
   assign o_rd    = i_instr[RD_MSB:RD_LSB];
   assign o_sh    = i_instr[SH_MSB:SH_LSB];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per req/ack
// handshake, holds it for the control unit and selects the next PC on
// consume (sequential or branch target from the datapath result).
// Optional feature macro: FETCH_ALIGN_FAULT_EN - an unaligned branch target
// raises a sticky align_fault and parks the unit until reset; without it the
// low target bits are simply cleared.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
);

   fetch_state_e      r_state;
   fetch_state_e      w_state_nxt;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic [ADDR_W-1:0] w_target;
   logic [31:0]       r_instr;
   logic              r_req;
   logic              r_valid;
   logic              w_load;
   logic              w_consume;
`ifdef FETCH_ALIGN_FAULT_EN
   logic              r_fault;
   logic              w_fault_set;
`endif

   logic [3:0] w_cond;
   logic [1:0] w_op;
   logic [5:0] w_funct;
   logic [3:0] w_rd;
   logic [1:0] w_sh;

   // A consume only counts while an instruction is actually held.
   assign w_consume = r_valid & bus.instr_ready;
   // Branch target forced onto a word boundary.
   assign w_target  = bus.result & ~(ADDR_W'(3));

   // Next-state and next-PC selection; ack/ready/pc_src only matter in the state that owns them.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_load      = 1'b0;
`ifdef FETCH_ALIGN_FAULT_EN
      w_fault_set = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            w_state_nxt = REQ;
         end
         REQ: begin
            if (bus.imem_ack) begin
               w_load      = 1'b1;
               w_state_nxt = HOLD;
            end else begin
               w_state_nxt = REQ;
            end
         end
         HOLD: begin
            if (w_consume) begin
`ifdef FETCH_ALIGN_FAULT_EN
               if (bus.pc_src && is_unaligned(bus.result[1:0])) begin
                  w_fault_set = 1'b1;
                  w_state_nxt = FAULT;
               end else begin
                  w_pc_nxt    = bus.pc_src ? w_target : (r_pc + ADDR_W'(4));
                  w_state_nxt = REQ;
               end
`else
               w_pc_nxt    = bus.pc_src ? w_target : (r_pc + ADDR_W'(4));
               w_state_nxt = REQ;
`endif
            end else begin
               w_state_nxt = HOLD;
            end
         end
`ifdef FETCH_ALIGN_FAULT_EN
         FAULT: begin
            w_state_nxt = FAULT;
         end
`endif
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Registered PC, instruction and handshake outputs, all following the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc    <= RESET_PC;
         r_instr <= 32'h0000_0000;
         r_req   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_pc    <= w_pc_nxt;
         r_req   <= (w_state_nxt == REQ);
         r_valid <= (w_state_nxt == HOLD);
         if (w_load) begin
            r_instr <= bus.imem_rdata;
         end else begin
            r_instr <= r_instr;
         end
      end
   end

`ifdef FETCH_ALIGN_FAULT_EN
   // Sticky alignment fault, cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fault <= 1'b0;
      end else begin
         r_fault <= r_fault | w_fault_set;
      end
   end

   assign bus.align_fault = r_fault;
`endif

   instr_splitter u_splitter (
      .i_instr (r_instr),
      .o_cond  (w_cond),
      .o_op    (w_op),
      .o_funct (w_funct),
      .o_rd    (w_rd),
      .o_sh    (w_sh)
   );

   assign bus.imem_req    = r_req;
   assign bus.imem_addr   = r_pc;
   assign bus.instr_valid = r_valid;
   assign bus.instr       = r_instr;
   assign bus.pc_plus8    = r_pc + ADDR_W'(8);
   assign bus.cond        = w_cond;
   assign bus.op          = w_op;
   assign bus.funct       = w_funct;
   assign bus.rd          = w_rd;
   assign bus.sh          = w_sh;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: decode-field vector table, hand-written
// handshake corner cases, randomized traffic against a transaction-level model,
// and a second instance with RESET_PC at the top of the address space.
module tb_fetch_unit;

`ifdef FETCH_ALIGN_FAULT_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic clk  = 1'b0;
   logic rst0 = 1'b0;
   logic rst1 = 1'b0;

   always #5 clk = ~clk;

   fetch_unit_if #(.ADDR_W(32)) bus0 ();
   fetch_unit_if #(.ADDR_W(32)) bus1 ();

   fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u0 (
      .clk (clk), .rst (rst0), .bus (bus0.master)
   );
   fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u1 (
      .clk (clk), .rst (rst1), .bus (bus1.master)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model of u0 (what the spec promises, one step per clock).
   bit          m_boot;
   bit          m_req;
   bit          m_valid;
   bit          m_fault;
   logic [31:0] m_pc;
   logic [31:0] m_instr;

   logic [31:0] xfers[$];
   int          rises;
   bit          prev_req;

   typedef struct {
      logic [31:0] word;
      logic [3:0]  cond;
      logic [1:0]  op;
      logic [5:0]  funct;
      logic [3:0]  rd;
      logic [1:0]  sh;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_compare();
      check("m_req",    {31'd0, bus0.imem_req},    {31'd0, m_req});
      check("m_valid",  {31'd0, bus0.instr_valid}, {31'd0, m_valid});
      check("m_addr",   bus0.imem_addr, m_pc);
      check("m_pc8",    bus0.pc_plus8,  m_pc + 32'd8);
      check("m_instr",  bus0.instr,     m_instr);
      check("m_cond",   {28'd0, bus0.cond},  {28'd0, m_instr[31:28]});
      check("m_op",     {30'd0, bus0.op},    {30'd0, m_instr[27:26]});
      check("m_funct",  {26'd0, bus0.funct}, {26'd0, m_instr[25:20]});
      check("m_rd",     {28'd0, bus0.rd},    {28'd0, m_instr[15:12]});
      check("m_sh",     {30'd0, bus0.sh},    {30'd0, m_instr[6:5]});
`ifdef FETCH_ALIGN_FAULT_EN
      check("m_fault",  {31'd0, bus0.align_fault}, {31'd0, m_fault});
`endif
   endtask

   task automatic model_reset();
      m_boot  = 1'b1;
      m_req   = 1'b0;
      m_valid = 1'b0;
      m_fault = 1'b0;
      m_pc    = 32'h0000_0000;
      m_instr = 32'h0000_0000;
   endtask

   // One clock of u0: capture inputs, clock, advance model, compare.
   task automatic cycle();
      logic        ack, rdy, psrc;
      logic [31:0] rdat, res;
      ack  = bus0.imem_ack;
      rdy  = bus0.instr_ready;
      psrc = bus0.pc_src;
      rdat = bus0.imem_rdata;
      res  = bus0.result;
      if (bus0.imem_req && ack) xfers.push_back(bus0.imem_addr);
      @(posedge clk);
      #1;
      if (m_boot) begin
         m_boot = 1'b0;
         m_req  = 1'b1;
      end else if (m_fault) begin
         m_req = 1'b0;
      end else if (m_req) begin
         if (ack) begin
            m_instr = rdat;
            m_req   = 1'b0;
            m_valid = 1'b1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
         if (ALIGN_EN && psrc && (res[1:0] != 2'b00)) begin
            m_fault = 1'b1;
         end else begin
            m_pc  = psrc ? (res & ~32'd3) : (m_pc + 32'd4);
            m_req = 1'b1;
         end
      end
      if (bus0.imem_req && !prev_req) rises++;
      prev_req = bus0.imem_req;
      model_compare();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] saved;
      logic [31:0] word;

      vecs[0] = '{32'hE3A0_1005, 4'hE, 2'b00, 6'b111010, 4'h1, 2'b00};
      vecs[1] = '{32'hFFFF_FFFF, 4'hF, 2'b11, 6'b111111, 4'hF, 2'b11};
      vecs[2] = '{32'h0000_0000, 4'h0, 2'b00, 6'b000000, 4'h0, 2'b00};
      vecs[3] = '{32'h0000_0060, 4'h0, 2'b00, 6'b000000, 4'h0, 2'b11};
      vecs[4] = '{32'h1C3F_A040, 4'h1, 2'b11, 6'b000011, 4'hA, 2'b10};
      vecs[5] = '{32'hA5A5_5A5A, 4'hA, 2'b01, 6'b011010, 4'h5, 2'b10};

      bus0.imem_ack = 1'b0; bus0.imem_rdata = 32'h0; bus0.instr_ready = 1'b0;
      bus0.pc_src = 1'b0;   bus0.result = 32'h0;
      bus1.imem_ack = 1'b0; bus1.imem_rdata = 32'h0; bus1.instr_ready = 1'b0;
      bus1.pc_src = 1'b0;   bus1.result = 32'h0;
      rises = 0; prev_req = 1'b0;
      model_reset();

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst_req",   {31'd0, bus0.imem_req},    32'd0);
      check("rst_valid", {31'd0, bus0.instr_valid}, 32'd0);
      check("rst_addr",  bus0.imem_addr, 32'h0000_0000);
      check("rst_pc8",   bus0.pc_plus8,  32'h0000_0008);
      check("rst_instr", bus0.instr,     32'h0000_0000);
      check("rst_flds",  {16'd0, bus0.cond, bus0.op, bus0.funct, bus0.rd, bus0.sh}, 32'd0);
`ifdef FETCH_ALIGN_FAULT_EN
      check("rst_fault", {31'd0, bus0.align_fault}, 32'd0);
`endif

      // Zero-wait streaming: addresses 0,4,8 and valid every second cycle.
      rst0 = 1'b1;
      bus0.imem_ack = 1'b1; bus0.instr_ready = 1'b1;
      xfers.delete();
      for (int i = 0; i < 6; i++) begin
         bus0.imem_rdata = $urandom;
         cycle();
         check("stream_valid", {31'd0, bus0.instr_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
      end
      check("stream_n", xfers.size(), 32'd3);
      if (xfers.size() == 3) begin
         check("stream_a0", xfers[0], 32'h0);
         check("stream_a1", xfers[1], 32'h4);
         check("stream_a2", xfers[2], 32'h8);
      end
      bus0.imem_ack = 1'b0; bus0.instr_ready = 1'b0;
      cycle();

      // Decode-field vector table (starts and ends in HOLD).
      for (int v = 0; v < 6; v++) begin
         bus0.instr_ready = 1'b1; cycle(); bus0.instr_ready = 1'b0;
         bus0.imem_ack = 1'b1; bus0.imem_rdata = vecs[v].word; cycle(); bus0.imem_ack = 1'b0;
         check("tbl_valid", {31'd0, bus0.instr_valid}, 32'd1);
         check("tbl_cond",  {28'd0, bus0.cond},  {28'd0, vecs[v].cond});
         check("tbl_op",    {30'd0, bus0.op},    {30'd0, vecs[v].op});
         check("tbl_funct", {26'd0, bus0.funct}, {26'd0, vecs[v].funct});
         check("tbl_rd",    {28'd0, bus0.rd},    {28'd0, vecs[v].rd});
         check("tbl_sh",    {30'd0, bus0.sh},    {30'd0, vecs[v].sh});
         check("tbl_pc8",   bus0.pc_plus8, bus0.imem_addr + 32'd8);
      end

      // pc_src without consume is ignored; branch on consume.
      saved = bus0.imem_addr;
      bus0.pc_src = 1'b1; bus0.result = 32'h0000_0080;
      cycle(); cycle();
      check("nobr_addr", bus0.imem_addr, saved);
      bus0.result = 32'h0000_0040; bus0.instr_ready = 1'b1;
      cycle();
      bus0.instr_ready = 1'b0;
      check("br_addr", bus0.imem_addr, 32'h0000_0040);
      check("br_req",  {31'd0, bus0.imem_req}, 32'd1);
      bus0.result = 32'h0000_0100; bus0.imem_ack = 1'b1;
      cycle();
      bus0.imem_ack = 1'b0; bus0.pc_src = 1'b0;
      check("br_hold_addr", bus0.imem_addr, 32'h0000_0040);

      // Delayed ack (3 cycles) and stalled consumer (4 cycles).
      rises = 0; xfers.delete();
      bus0.instr_ready = 1'b1; cycle(); bus0.instr_ready = 1'b0;
      check("seq_addr", bus0.imem_addr, 32'h0000_0044);
      for (int w = 0; w < 3; w++) begin
         cycle();
         check("wait_addr", bus0.imem_addr, 32'h0000_0044);
         check("wait_req",  {31'd0, bus0.imem_req}, 32'd1);
      end
      word = 32'hE59F_1234;
      bus0.imem_ack = 1'b1; bus0.imem_rdata = word; cycle();
      bus0.imem_ack = 1'b0; bus0.imem_rdata = 32'hDEAD_BEEF;
      for (int w = 0; w < 4; w++) begin
         cycle();
         check("stall_instr", bus0.instr, word);
         check("stall_valid", {31'd0, bus0.instr_valid}, 32'd1);
      end
      check("one_req", rises, 32'd1);
      check("one_xfer", xfers.size(), 32'd1);

      // Randomized traffic against the model.
      for (int r = 0; r < 400; r++) begin
         bus0.imem_ack    = ($urandom_range(1, 0) == 1);
         bus0.instr_ready = ($urandom_range(1, 0) == 1);
         bus0.pc_src      = ($urandom_range(3, 0) == 0);
         bus0.imem_rdata  = $urandom;
         bus0.result      = ALIGN_EN ? ($urandom & ~32'd3) : $urandom;
         cycle();
      end

      // Reach HOLD, then branch to an unaligned target.
      bus0.imem_ack = 1'b1; bus0.instr_ready = 1'b0; bus0.pc_src = 1'b0;
      for (int t = 0; t < 10 && !bus0.instr_valid; t++) cycle();
      check("pre_fault_valid", {31'd0, bus0.instr_valid}, 32'd1);
      bus0.imem_ack = 1'b0;
      bus0.pc_src = 1'b1; bus0.result = 32'h0000_0042; bus0.instr_ready = 1'b1;
      cycle();
`ifdef FETCH_ALIGN_FAULT_EN
      check("fault_flag", {31'd0, bus0.align_fault}, 32'd1);
      bus0.imem_ack = 1'b1;
      for (int t = 0; t < 3; t++) begin
         cycle();
         check("fault_req", {31'd0, bus0.imem_req}, 32'd0);
      end
`else
      check("unal_addr", bus0.imem_addr, 32'h0000_0040);
      check("unal_req",  {31'd0, bus0.imem_req}, 32'd1);
`endif

      // Second instance: wrap from the top of memory, and reset mid-request.
      #1;
      check("u1_rst_addr", bus1.imem_addr, 32'hFFFF_FFFC);
      check("u1_rst_pc8",  bus1.pc_plus8,  32'h0000_0004);
      check("u1_rst_req",  {31'd0, bus1.imem_req}, 32'd0);
      @(posedge clk); #1;
      rst1 = 1'b1;
      bus1.imem_ack = 1'b1; bus1.instr_ready = 1'b1; bus1.imem_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      check("u1_a0", bus1.imem_addr, 32'hFFFF_FFFC);
      check("u1_r0", {31'd0, bus1.imem_req}, 32'd1);
      @(posedge clk); #1;
      check("u1_v0", {31'd0, bus1.instr_valid}, 32'd1);
      bus1.imem_ack = 1'b0;
      @(posedge clk); #1;
      check("u1_wrap", bus1.imem_addr, 32'h0000_0000);
      check("u1_r1",   {31'd0, bus1.imem_req}, 32'd1);
      #2;
      rst1 = 1'b0;
      #1;
      check("u1_async_req",  {31'd0, bus1.imem_req}, 32'd0);
      check("u1_async_addr", bus1.imem_addr, 32'hFFFF_FFFC);
      bus1.imem_ack = 1'b1;
      @(posedge clk); #1;
      check("u1_rst_ack_req",   {31'd0, bus1.imem_req},    32'd0);
      check("u1_rst_ack_valid", {31'd0, bus1.instr_valid}, 32'd0);
      check("u1_rst_ack_instr", bus1.instr, 32'h0000_0000);
      rst1 = 1'b1;
      bus1.imem_ack = 1'b0;
      @(posedge clk); #1;
      check("u1_restart_req",  {31'd0, bus1.imem_req}, 32'd1);
      check("u1_restart_addr", bus1.imem_addr, 32'hFFFF_FFFC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
